// File: rtl/alu_share_arbiter_pkg.sv
// Shared widths, Alu opcodes and port IDs for the shared-Alu arbiter slice.
package alu_share_arbiter_pkg;

    localparam int IMM_WIDTH   = 64;
    localparam int ALUOP_WIDTH = 5;
    localparam int SHT_WDT     = 6;

    localparam logic [ALUOP_WIDTH-1:0] ALU_ADD  = 5'd0;
    localparam logic [ALUOP_WIDTH-1:0] ALU_SUB  = 5'd1;
    localparam logic [ALUOP_WIDTH-1:0] ALU_AND  = 5'd2;
    localparam logic [ALUOP_WIDTH-1:0] ALU_OR   = 5'd3;
    localparam logic [ALUOP_WIDTH-1:0] ALU_XOR  = 5'd4;
    localparam logic [ALUOP_WIDTH-1:0] ALU_SLL  = 5'd5;
    localparam logic [ALUOP_WIDTH-1:0] ALU_SRL  = 5'd6;
    localparam logic [ALUOP_WIDTH-1:0] ALU_SRA  = 5'd7;
    localparam logic [ALUOP_WIDTH-1:0] ALU_SLT  = 5'd8;
    localparam logic [ALUOP_WIDTH-1:0] ALU_SLTU = 5'd9;
    localparam logic [ALUOP_WIDTH-1:0] ALU_ADDW = 5'd10;
    localparam logic [ALUOP_WIDTH-1:0] ALU_SUBW = 5'd11;

    localparam logic PORT_EXU = 1'b0;
    localparam logic PORT_BRU = 1'b1;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational integer Alu; unknown opcodes yield zero.
module alu
    import alu_share_arbiter_pkg::*;
#(
    parameter int DATA_W = IMM_WIDTH,
    parameter int OP_W   = ALUOP_WIDTH
) (
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
);

    logic [SHT_WDT-1:0] shamt;
    logic [31:0]        sum_w;
    logic [31:0]        diff_w;

    always_comb begin
        shamt  = b[SHT_WDT-1:0];
        sum_w  = a[31:0] + b[31:0];
        diff_w = a[31:0] - b[31:0];
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $signed(a) >>> shamt;
            ALU_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
            // Word ops compute on the low 32 bits and sign-extend bit 31.
            ALU_ADDW: result = {{(DATA_W-32){sum_w[31]}}, sum_w};
            ALU_SUBW: result = {{(DATA_W-32){diff_w[31]}}, diff_w};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin picker with a starvation bound; produces a one-hot grant.
module rr_arb2
    import alu_share_arbiter_pkg::*;
#(
    parameter int CNT_W      = 3,
    parameter int STARVE_MAX = 4
) (
    input  logic [1:0]       valid,
    input  logic             last_grant,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic [1:0]       grant
);

    logic rr_pick;
    logic force_other;
    logic pick;

    // Round-robin already favours the port not served last; the starvation
    // bound forces that same port and is kept as a safety net.
    always_comb begin
        rr_pick     = ~last_grant;
        force_other = (starve_cnt >= CNT_W'(STARVE_MAX));
        pick        = force_other ? ~last_grant : rr_pick;
        grant       = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (pick == PORT_BRU) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one Alu between the EXU (port 0) and branch unit (port 1); results
// are held in a one-entry tagged output slot until the consumer accepts them.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int DATA_W     = IMM_WIDTH,
    parameter int OP_W       = ALUOP_WIDTH,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_data,
    output logic              busy
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic              resp_valid_q, resp_valid_d;
    logic              resp_id_q, resp_id_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;

    logic              slot_free;
    logic [1:0]        arb_grant;
    logic [1:0]        grant;
    logic              gnt_any;
    logic              gnt_id;
    logic              other_valid;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_y;

    assign slot_free = !resp_valid_q || resp_ready;

    rr_arb2 #(
        .CNT_W      (CNT_W),
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .starve_cnt (starve_cnt_q),
        .grant      (arb_grant)
    );

    assign grant      = slot_free ? arb_grant : 2'b00;
    assign gnt_any    = |grant;
    assign gnt_id     = grant[1];
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    assign alu_op = (gnt_id == PORT_BRU) ? req1_op : req0_op;
    assign alu_a  = (gnt_id == PORT_BRU) ? req1_a  : req0_a;
    assign alu_b  = (gnt_id == PORT_BRU) ? req1_b  : req0_b;

    alu #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_alu (
        .op     (alu_op),
        .a      (alu_a),
        .b      (alu_b),
        .result (alu_y)
    );

    // A grant overwrites the slot even when it is being accepted in the same
    // cycle, which is what sustains one result per cycle.
    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        last_grant_d = last_grant_q;
        starve_cnt_d = starve_cnt_q;
        other_valid  = (gnt_id == PORT_BRU) ? req0_valid : req1_valid;
        if (gnt_any) begin
            resp_valid_d = 1'b1;
            resp_id_d    = gnt_id;
            resp_data_d  = alu_y;
            last_grant_d = gnt_id;
            if (other_valid && (gnt_id == last_grant_q)) begin
                if (starve_cnt_q < CNT_W'(STARVE_MAX)) begin
                    starve_cnt_d = starve_cnt_q + 1'b1;
                end
            end else begin
                starve_cnt_d = '0;
            end
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_id_q    <= PORT_EXU;
            resp_data_q  <= '0;
            last_grant_q <= PORT_BRU;
            starve_cnt_q <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            last_grant_q <= last_grant_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign busy       = resp_valid_q || req0_valid || req1_valid;

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares the single integer Alu datapath between two requesters: port 0 is the EXU main path and port 1 is the branch/address unit.
- Arbitration is round-robin, one operation per cycle.
- Valid/ready handshakes are used on both request ports and on the response port.
- Each result is registered in a one-entry output slot, tagged with the requester ID, and held until the consumer accepts it.
- The block sits between decode/issue and writeback and instantiates one Alu.

Parameters:
- DATA_W, 64, operand/result width; matches the team ImmWidth.
- OP_W, 5, ALU opcode width; matches the team AluopWidth.
- STARVE_MAX, 4, maximum consecutive grants to one port while the other is waiting.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an op.
- req0_ready  out  1  requester 0 op accepted this cycle.
- req0_op  in  OP_W  ALU opcode.
- req0_a  in  DATA_W  operand 1.
- req0_b  in  DATA_W  operand 2.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as port 0, for requester 1.
- resp_valid  out  1  result slot full.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  1  source port of the result.
- resp_data  out  DATA_W  registered ALU result.
- busy  out  1  resp_valid OR any req_valid; used for the pipeline-drain check.

Behaviour:
- Reset (asynchronous, while rst_n=0): resp_valid=0, resp_data=0, resp_id=0, last_grant=1 (so port 0 wins first), starve_cnt=0. Reset mid-operation discards the held result and any pending grant.
- slot_free = !resp_valid OR resp_ready. Grants are issued only when slot_free=1.
- Grant selection (combinational):
  - One valid requester: it is granted.
  - Both valid: the port != last_grant is granted, unless starve_cnt has reached STARVE_MAX for that port, in which case the other port is forced. With strict alternation this force never fires; it is kept as a safety bound.
  - reqN_ready = grantN. At most one ready is high per cycle.
- Operand mux: operands and opcode of the granted port feed the Alu. The Alu is combinational; latency is 1 cycle from request handshake to resp_valid.
- Result capture on the rising edge when a grant is given: resp_data <= Alu result, resp_id <= granted port, resp_valid <= 1, last_grant <= granted port.
- Simultaneous accept and issue (resp_valid & resp_ready & grant): the new result replaces the old one with resp_valid held at 1. Throughput is 1 op per cycle.
- Accept with no grant: resp_valid <= 0. resp_data and resp_id hold their previous values (don't-care when not valid).
- Output stall (resp_valid=1, resp_ready=0): both reqN_ready=0; resp_data and resp_id are stable; requesters must hold their inputs stable.
- Request stability: while reqN_valid=1 and reqN_ready=0, opcode and operands must not change. The bench checks this as an assertion.
- starve_cnt: increments when the same port is granted while the other port is valid; clears on a grant to the other port or when the other port is idle.
- Arithmetic and width rules follow Alu:
  - Shifts use operand2[5:0].
  - addw sign-extends bit 31.
  - Compare ops zero-extend 1 bit.
  - An unknown opcode produces 0.
- Invariants: no requester is ever granted without valid; no result is dropped; there is no combinational path from resp_ready to resp_data.

Decomposition:
- Shared package (existing defines include): DATA_W/ImmWidth, OP_W/AluopWidth, the Alu* opcode constants, ShtWdt.
- Local: port-ID constants PORT_EXU=0, PORT_BRU=1.
- One natural sub-module: rr_arb2, the two-way round-robin picker with starvation counter (inputs: valids, last_grant, starve_cnt; outputs: one-hot grant).
- The Alu is instantiated as-is.

Test Plan:
- Reset then single request: req0 add a=5, b=3 → req0_ready=1 in cycle 0; resp_valid=1, resp_data=8, resp_id=0 at cycle 1. Apply reset mid-hold → resp_valid=0 immediately.
- Both valid continuously, resp_ready=1: req0 sub(10,4) and req1 xor(0xF0,0xFF) → grants alternate 0,1,0,1. Results 6 and 0x0F stream at 1 per cycle with alternating resp_id.
- Backpressure: resp_ready=0 for 3 cycles with both valid → both readys low and resp_data stable. Release → the held result is accepted and the next grant is issued in the same cycle with no bubble.
- Width ops, issued back-to-back:
  - addw(0x7FFFFFFF, 1) → 0xFFFFFFFF80000000.
  - sra(0x8000000000000000, 63) → all-ones.
  - sll(1, 64) → 1, because the shift amount is masked to 0.
  - ltu(1, -1) → 1.
- Starvation and random traffic: 10k cycles of random valids, ops and resp_ready → no lost or duplicated ops. The scoreboard matches results per port in order. No port waits more than STARVE_MAX+1 grants.
